// File: rtl/player_ctrl.sv
// player_ctrl: per-player controller for the tennis/squash game.
//
// The block watches the ball's hittable window and the player's swing button.
// A swing that lands inside the window produces a one-cycle return pulse. A
// window that closes without a swing costs a life, unless squash (practice)
// mode is on. When the last life is lost the block raises match and stays in
// OVER until start_game is dropped.
//
// Ports
//   clk            in   1  system clock, rising edge
//   rst            in   1  asynchronous, active-low reset
//   ret            out  1  one-cycle pulse: ball returned ("return" is a
//                          reserved word in SystemVerilog, hence the short name)
//   life           out  2  remaining lives
//   match          out  1  high while game over (lives exhausted)
//   button         in   1  raw swing button, asynchronous, active-high
//   hittable_ball  in   1  ball-in-reach window, synchronous to clk
//   start_game     in   1  level; high starts/continues a game
//   squash_en      in   1  practice mode: misses do not cost lives
//
// Parameters
//   LIVES           lives loaded at game start (1..3)
//   LOCKOUT_CYCLES  swing-lockout length after a whiff
//
// Build option
//   PLAYER_LOCKOUT_EN  when defined, a whiff in READY starts a LOCKOUT_CYCLES
//                      down-counter; presses are ignored while it is non-zero.
//                      When undefined, whiffs have no effect and no counter
//                      exists.
//
// States
//   IDLE   | no game running; waits for start_game
//   READY  | game running, ball out of reach
//   WINDOW | ball hittable, waiting for a swing
//   HIT    | ball returned; waits for the window to close
//   OVER   | lives exhausted; match high until start_game drops

module player_ctrl #(
  parameter int LIVES          = 3,
  parameter int LOCKOUT_CYCLES = 4
) (
  input  logic       clk,
  input  logic       rst,
  output logic       ret,
  output logic [1:0] life,
  output logic       match,
  input  logic       button,
  input  logic       hittable_ball,
  input  logic       start_game,
  input  logic       squash_en
);

  localparam logic [1:0] LIVES_INIT = 2'(LIVES);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    READY  = 3'd1,
    WINDOW = 3'd2,
    HIT    = 3'd3,
    OVER   = 3'd4
  } state_t;

  state_t     state;
  state_t     state_nxt;
  logic       ret_nxt;
  logic [1:0] life_nxt;
  logic       match_nxt;

  // Button conditioning: two-flop synchronizer plus an edge flop, so a held
  // button yields a single press strobe.
  logic sync1;
  logic sync2;
  logic prev;
  logic press;
  logic press_ok;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sync1 <= 1'b0;
      sync2 <= 1'b0;
      prev  <= 1'b0;
    end else begin
      sync1 <= button;
      sync2 <= sync1;
      prev  <= sync2;
    end
  end

  assign press = sync2 & ~prev;

`ifdef PLAYER_LOCKOUT_EN
  localparam int LW = (LOCKOUT_CYCLES < 1) ? 1 : $clog2(LOCKOUT_CYCLES + 1);

  logic [LW-1:0] lock_cnt;

  // Runs across state changes; only IDLE and reset clear it. A press that is
  // itself locked out does not re-arm the counter.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      lock_cnt <= '0;
    end else if (state == IDLE) begin
      lock_cnt <= '0;
    end else if (state == READY && press_ok) begin
      lock_cnt <= LW'(LOCKOUT_CYCLES);
    end else if (lock_cnt != '0) begin
      lock_cnt <= lock_cnt - LW'(1);
    end
  end

  assign press_ok = press & (lock_cnt == '0);
`else
  assign press_ok = press;
`endif

  logic       hit;
  logic       miss;
  logic [1:0] life_dec;

  assign hit      = press_ok & hittable_ball;
  assign miss     = ~hittable_ball;
  assign life_dec = (life == 2'd0) ? 2'd0 : life - 2'd1;

  // State and registered outputs.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= IDLE;
      ret   <= 1'b0;
      life  <= 2'd0;
      match <= 1'b0;
    end else begin
      state <= state_nxt;
      ret   <= ret_nxt;
      life  <= life_nxt;
      match <= match_nxt;
    end
  end

  // Next-state logic. Dropping start_game aborts any running rally.
  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE: begin
        if (start_game) state_nxt = READY;
      end
      READY: begin
        if (!start_game)        state_nxt = IDLE;
        else if (hittable_ball) state_nxt = WINDOW;
      end
      WINDOW: begin
        if (!start_game) begin
          state_nxt = IDLE;
        end else if (hit) begin
          state_nxt = HIT;
        end else if (miss) begin
          if (!squash_en && life_dec == 2'd0) state_nxt = OVER;
          else                                state_nxt = READY;
        end
      end
      HIT: begin
        if (!start_game)         state_nxt = IDLE;
        else if (!hittable_ball) state_nxt = READY;
      end
      OVER: begin
        if (!start_game) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Next values of the registered outputs.
  always_comb begin
    ret_nxt   = 1'b0;
    life_nxt  = life;
    match_nxt = match;
    unique case (state)
      IDLE: begin
        if (start_game) begin
          life_nxt  = LIVES_INIT;
          match_nxt = 1'b0;
        end
      end
      WINDOW: begin
        if (start_game) begin
          if (hit) begin
            ret_nxt = 1'b1;
          end else if (miss && !squash_en) begin
            life_nxt = life_dec;
            if (life_dec == 2'd0) match_nxt = 1'b1;
          end
        end
      end
      OVER: begin
        life_nxt  = 2'd0;
        match_nxt = 1'b1;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_player_ctrl.sv
module tb_player_ctrl;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       ret;
  logic [1:0] life;
  logic       match;
  logic       button = 1'b0;
  logic       hittable_ball = 1'b0;
  logic       start_game = 1'b0;
  logic       squash_en = 1'b0;

  int checks = 0;
  int failures = 0;

  player_ctrl dut (
    .clk          (clk),
    .rst          (rst),
    .ret          (ret),
    .life         (life),
    .match        (match),
    .button       (button),
    .hittable_ball(hittable_ball),
    .start_game   (start_game),
    .squash_en    (squash_en)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic       btn;
    logic       hb;
    logic       sg;
    logic       sq;
    logic       e_ret;
    logic [1:0] e_life;
    logic       e_match;
  } vec_t;

  vec_t vecs[$];

  task automatic add(input logic b, input logic h, input logic s, input logic q,
                     input logic r, input logic [1:0] l, input logic m);
    vec_t v;
    v.btn = b; v.hb = h; v.sg = s; v.sq = q;
    v.e_ret = r; v.e_life = l; v.e_match = m;
    vecs.push_back(v);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input int got, input int exp);
    checks++;
    if (got != exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", name, got, exp);
    end
  endtask

  task automatic chk_out(input string tag, input logic r, input logic [1:0] l, input logic m);
    chk({tag, " ret"}, int'(ret), int'(r));
    chk({tag, " life"}, int'(life), int'(l));
    chk({tag, " match"}, int'(match), int'(m));
  endtask

  initial begin
    // button propagates to a press strobe that acts on the third edge after
    // it is set, so a row with btn=1 shows its effect two rows later.
    //  btn hb sg sq | ret life match
    add(0,0,1,0, 0,3,0); // 0  IDLE->READY, lives loaded
    add(0,1,1,0, 0,3,0); // 1  READY->WINDOW
    add(1,1,1,0, 0,3,0); // 2  button rises inside window
    add(1,1,1,0, 0,3,0); // 3
    add(1,1,1,0, 1,3,0); // 4  press lands -> HIT, return
    add(0,1,1,0, 0,3,0); // 5  HIT held, single return
    add(0,0,1,0, 0,3,0); // 6  -> READY
    add(0,1,1,0, 0,3,0); // 7  window 3 cycles, no swing
    add(0,1,1,0, 0,3,0); // 8
    add(0,1,1,0, 0,3,0); // 9
    add(0,0,1,0, 0,2,0); // 10 miss: 3->2
    add(0,1,1,0, 0,2,0); // 11
    add(0,0,1,0, 0,1,0); // 12 miss: 2->1
    add(0,1,1,1, 0,1,0); // 13 squash mode window
    add(0,0,1,1, 0,1,0); // 14 squash miss: no loss
    add(0,1,1,0, 0,1,0); // 15
    add(0,0,1,0, 0,0,1); // 16 last life lost -> OVER
    add(1,1,1,0, 0,0,1); // 17 swing in OVER ignored
    add(1,1,1,0, 0,0,1); // 18
    add(1,1,1,0, 0,0,1); // 19 press in OVER: no return
    add(0,0,0,0, 0,0,1); // 20 OVER->IDLE, match held
    add(0,0,1,0, 0,3,0); // 21 restart clears match
    add(1,0,1,0, 0,3,0); // 22 button held before window
    add(1,0,1,0, 0,3,0); // 23
    add(1,0,1,0, 0,3,0); // 24 whiff in READY: no change
    add(1,1,1,0, 0,3,0); // 25 window opens, still held
    add(1,1,1,0, 0,3,0); // 26
    add(1,1,1,0, 0,3,0); // 27 no return
    add(1,0,1,0, 0,2,0); // 28 window closes -> miss
    add(0,1,1,0, 0,2,0); // 29 WINDOW
    add(0,0,0,0, 0,2,0); // 30 abort: IDLE, no loss
    add(0,0,0,0, 0,2,0); // 31 life held in IDLE
    add(0,0,1,0, 0,3,0); // 32 restart
    add(1,1,1,0, 0,3,0); // 33 WINDOW
    add(1,1,1,0, 0,3,0); // 34
    add(0,0,1,0, 0,2,0); // 35 press as window drops: miss
    add(1,0,1,0, 0,2,0); // 36
    add(0,1,1,0, 0,2,0); // 37 READY->WINDOW
    add(0,1,1,0, 1,2,0); // 38 press on first WINDOW cycle -> HIT
    add(0,1,1,0, 0,2,0); // 39 HIT held, no second return
    add(0,0,1,0, 0,2,0); // 40 -> READY

    #2;
    chk_out("reset_async", 1'b0, 2'd0, 1'b0);
    #6;
    chk_out("reset_edge", 1'b0, 2'd0, 1'b0);
    #2;
    rst = 1'b1;

    foreach (vecs[i]) begin
      button        = vecs[i].btn;
      hittable_ball = vecs[i].hb;
      start_game    = vecs[i].sg;
      squash_en     = vecs[i].sq;
      tick();
      chk_out($sformatf("vec%0d", i), vecs[i].e_ret, vecs[i].e_life, vecs[i].e_match);
    end

`ifdef PLAYER_LOCKOUT_EN
    // Whiff in READY, then a press early in the next window is locked out;
    // a fresh press after the counter expires returns the ball.
    button = 1'b1;
    tick(); tick(); tick();
    chk_out("lock_whiff", 1'b0, 2'd2, 1'b0);
    hittable_ball = 1'b1;
    tick(); tick(); tick();
    chk_out("lock_blocked", 1'b0, 2'd2, 1'b0);
    button = 1'b0;
    tick();
    chk("lock_blocked2 ret", int'(ret), 0);
    tick();
    chk("lock_blocked3 ret", int'(ret), 0);
    button = 1'b1;
    tick(); tick();
    chk("lock_pre ret", int'(ret), 0);
    tick();
    chk_out("lock_expired", 1'b1, 2'd2, 1'b0);
    button = 1'b0;
    hittable_ball = 1'b0;
    tick();
    chk("lock_after ret", int'(ret), 0);
`endif

    // Asynchronous reset mid-game clears outputs without a clock edge.
    button = 1'b0;
    hittable_ball = 1'b0;
    start_game = 1'b1;
    #3;
    rst = 1'b0;
    #1;
    chk_out("mid_reset", 1'b0, 2'd0, 1'b0);
    tick();
    rst = 1'b1;
    start_game = 1'b0;
    tick();
    chk_out("post_reset_idle", 1'b0, 2'd0, 1'b0);
    start_game = 1'b1;
    tick();
    chk_out("post_reset_start", 1'b0, 2'd3, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
